// File: rtl/mix_tree_scheduler_pkg.sv
// mixtree_pkg: shared types and constants for the mixing-tree scheduler.
//   phase_t   : run phase encoding, also driven on the phase output
//   N_MIXERS  : mixers in the tree (4 leaves, 2 middle, 1 root)
//   LVLn_MASK : mixers belonging to tree level n
//   LVLn_CHILD_A/B : outlet valves of the a/b children feeding level n
// Mixer 4 is fed by (0,1), mixer 5 by (2,3), root 6 by (4,5).
package mixtree_pkg;

  localparam int N_MIXERS = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL_A = 3'd1,
    FILL_B = 3'd2,
    MIX    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } phase_t;

  localparam logic [N_MIXERS-1:0] LVL0_MASK = 7'h0F;
  localparam logic [N_MIXERS-1:0] LVL1_MASK = 7'h30;
  localparam logic [N_MIXERS-1:0] LVL2_MASK = 7'h40;

  localparam logic [N_MIXERS-1:0] LVL1_CHILD_A = 7'h05;
  localparam logic [N_MIXERS-1:0] LVL1_CHILD_B = 7'h0A;
  localparam logic [N_MIXERS-1:0] LVL2_CHILD_A = 7'h10;
  localparam logic [N_MIXERS-1:0] LVL2_CHILD_B = 7'h20;

  function automatic logic [N_MIXERS-1:0] level_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return LVL0_MASK;
      2'd1:    return LVL1_MASK;
      2'd2:    return LVL2_MASK;
      default: return '0;
    endcase
  endfunction

  // Leaves have no children, so level 0 drains nothing while filling.
  function automatic logic [N_MIXERS-1:0] child_a_mask(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return LVL1_CHILD_A;
      2'd2:    return LVL2_CHILD_A;
      default: return '0;
    endcase
  endfunction

  function automatic logic [N_MIXERS-1:0] child_b_mask(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return LVL1_CHILD_B;
      2'd2:    return LVL2_CHILD_B;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mix_tree_scheduler_if.sv
// mix_tree_scheduler_if: host/valve-bank signal bundle for the scheduler.
//   master : run-control side (drives start/abort/pressure_ok, observes rest)
//   slave  : scheduler side
//   run_cycles exists only when MIXTREE_CYCLE_COUNT_EN is defined.
interface mix_tree_scheduler_if;
  import mixtree_pkg::*;

  logic                start;
  logic                abort;
  logic                pressure_ok;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [N_MIXERS-1:0] fill_a;
  logic [N_MIXERS-1:0] fill_b;
  logic [N_MIXERS-1:0] mix_en;
  logic [N_MIXERS-1:0] drain;
  logic [1:0]          level;
  phase_t              phase;
`ifdef MIXTREE_CYCLE_COUNT_EN
  logic [15:0]         run_cycles;
`endif

  modport master (
    output start, abort, pressure_ok,
    input  busy, done, aborted, fill_a, fill_b, mix_en, drain, level, phase
`ifdef MIXTREE_CYCLE_COUNT_EN
    , input run_cycles
`endif
  );

  modport slave (
    input  start, abort, pressure_ok,
    output busy, done, aborted, fill_a, fill_b, mix_en, drain, level, phase
`ifdef MIXTREE_CYCLE_COUNT_EN
    , output run_cycles
`endif
  );

endinterface

// File: rtl/mix_tree_scheduler_phase_timer.sv
// mixtree_phase_timer: phase down-counter with terminal-count flag.
//   load/load_val : reload at phase entry (param-1)
//   en            : decrement while nonzero
//   zero          : terminal count reached, phase ends this cycle
module mixtree_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mix_tree_scheduler.sv
// mix_tree_scheduler: valve sequencer for a 3-level binary mixing tree.
//   clk, rst_n : system clock, async active-low reset
//   bus.slave  : start/abort/pressure_ok in; busy/done/aborted pulses,
//                per-mixer fill_a/fill_b/mix_en/drain valves, level, phase out
// Optional: MIXTREE_CYCLE_COUNT_EN adds bus.run_cycles (busy-cycle counter).
//
// state  | meaning
// IDLE   | waiting for start
// FILL_A | fill A inlets of current level, drain a-children into them
// FILL_B | fill B inlets of current level, drain b-children into them
// MIX    | run mix pumps of current level
// DRAIN  | open root outlet to result port
// DONE   | one-cycle completion pulse
module mix_tree_scheduler
  import mixtree_pkg::*;
#(
  parameter int FILL_CYCLES  = 4,
  parameter int MIX_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input logic           clk,
  input logic           rst_n,
  mix_tree_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIX_LD   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

  phase_t              state, state_nxt;
  logic [1:0]          lvl, lvl_nxt;
  logic                t_load, t_en, t_zero;
  logic [CNT_W-1:0]    t_val;
  logic                hold, take_abort;

  logic                busy_q, done_q, aborted_q;
  logic                busy_n, done_n, aborted_n;
  logic [N_MIXERS-1:0] fa_q, fb_q, me_q, dr_q;
  logic [N_MIXERS-1:0] fa_n, fb_n, me_n, dr_n;

  mixtree_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // State and output registers; outputs are computed from the next state
  // so the valves change on the same edge the state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lvl       <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      fa_q      <= '0;
      fb_q      <= '0;
      me_q      <= '0;
      dr_q      <= '0;
    end else begin
      state     <= state_nxt;
      lvl       <= lvl_nxt;
      busy_q    <= busy_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      fa_q      <= fa_n;
      fb_q      <= fb_n;
      me_q      <= me_n;
      dr_q      <= dr_n;
    end
  end

  always_comb begin
    state_nxt  = state;
    lvl_nxt    = lvl;
    t_load     = 1'b0;
    t_en       = 1'b0;
    t_val      = '0;
    hold       = 1'b0;
    take_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FILL_A;
          lvl_nxt   = 2'd0;
          t_load    = 1'b1;
          t_val     = FILL_LD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        lvl_nxt   = 2'd0;
      end
      default: begin
        // Abort beats a pressure hold; a hold freezes timer and state.
        if (bus.abort) begin
          take_abort = 1'b1;
          state_nxt  = IDLE;
          lvl_nxt    = 2'd0;
        end else if (!bus.pressure_ok) begin
          hold = 1'b1;
        end else if (!t_zero) begin
          t_en = 1'b1;
        end else begin
          case (state)
            FILL_A: begin
              state_nxt = FILL_B;
              t_load    = 1'b1;
              t_val     = FILL_LD;
            end
            FILL_B: begin
              state_nxt = MIX;
              t_load    = 1'b1;
              t_val     = MIX_LD;
            end
            MIX: begin
              t_load = 1'b1;
              if (lvl == 2'd2) begin
                state_nxt = DRAIN;
                t_val     = DRAIN_LD;
              end else begin
                state_nxt = FILL_A;
                lvl_nxt   = lvl + 2'd1;
                t_val     = FILL_LD;
              end
            end
            default: state_nxt = DONE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    busy_n    = state_nxt inside {FILL_A, FILL_B, MIX, DRAIN};
    done_n    = (state_nxt == DONE);
    aborted_n = take_abort;
    fa_n      = '0;
    fb_n      = '0;
    me_n      = '0;
    dr_n      = '0;
    if (!hold) begin
      case (state_nxt)
        FILL_A: begin
          fa_n = level_mask(lvl_nxt);
          dr_n = child_a_mask(lvl_nxt);
        end
        FILL_B: begin
          fb_n = level_mask(lvl_nxt);
          dr_n = child_b_mask(lvl_nxt);
        end
        MIX:     me_n = level_mask(lvl_nxt);
        DRAIN:   dr_n = LVL2_MASK;
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.fill_a  = fa_q;
  assign bus.fill_b  = fb_q;
  assign bus.mix_en  = me_q;
  assign bus.drain   = dr_q;
  assign bus.level   = lvl;
  assign bus.phase   = state;

`ifdef MIXTREE_CYCLE_COUNT_EN
  logic [15:0] run_cnt;

  // Loading 1 on start counts the first busy cycle, so the value seen
  // during the run equals busy cycles elapsed so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= 16'd0;
    end else if (state == IDLE && bus.start) begin
      run_cnt <= 16'd1;
    end else if (busy_n && run_cnt != 16'hFFFF) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end

  assign bus.run_cycles = run_cnt;
`endif

endmodule

// File: doc/mix_tree_scheduler.md
Name: mix_tree_scheduler

Overview:
- Sequences the valves of a 7-mixer, 3-level binary mixing tree (4 leaf mixers, 2 middle, 1 root) in a flow-based biochip.
- For each tree level in turn, it drives two fill phases, then a mix phase, then drains the root to the result port.
- Sits between the run-control host and the valve-driver bank, one bit per mixer per valve function.
- Pressure-loss hold and abort are supported.

Parameters:
- FILL_CYCLES, 4, cycles per fill phase (≥1).
- MIX_CYCLES, 8, cycles per mix phase (≥1).
- DRAIN_CYCLES, 4, cycles for the final root drain (≥1).
- CNT_W, 8, phase-timer width; must hold max(param)-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE.
- abort  in  1  synchronous abort; honoured in any non-IDLE state.
- pressure_ok  in  1  low = hold (freeze).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse after abort.
- fill_a  out  7  per-mixer A-inlet valve.
- fill_b  out  7  per-mixer B-inlet valve.
- mix_en  out  7  per-mixer peristaltic mix pump.
- drain  out  7  per-mixer outlet valve; drain[6] is the result valve.
- level  out  2  current tree level (0 leaves, 1 middle, 2 root).
- phase  out  3  current phase encoding (package enum).
- run_cycles  out  16  cycles of last or current run; present only with MIXTREE_CYCLE_COUNT_EN.

Behaviour:
- Mixer indices:
  - Leaves are 0..3, middle mixers are 4 and 5, root is 6.
  - Children of 4 are (a=0, b=1); of 5 are (2, 3); of 6 are (4, 5).
- State sequence: IDLE → {FILL_A, FILL_B, MIX} for level 0, then level 1, then level 2 → DRAIN → DONE → IDLE.
- Phase timing:
  - Each phase lasts exactly its parameter's cycle count.
  - Timer loads param-1 on entry, decrements, and advances on zero.
- All outputs are registered. Reset values: all valve vectors 0; busy, done and aborted 0; level 0; phase IDLE; run_cycles 0.
- Valve drive during active states (no other bit set):
  - FILL_A: fill_a set for every mixer of the current level. At level ≥1, drain[child_a] is also set for each of those mixers.
  - FILL_B: same as FILL_A, using fill_b and child_b.
  - MIX: mix_en set for the current level's mixers.
  - DRAIN: drain[6] only.
- busy is high from the cycle after start is sampled through the last DRAIN cycle.
- Completion:
  - DONE lasts 1 cycle: done=1, busy=0, all valves 0.
  - With defaults, the sequence is 3×(4+4+8)+4 = 52 busy cycles; done is at cycle 53 after the start edge.
- start while not in IDLE is ignored.
- Hold:
  - When pressure_ok=0 in an active state, all valve outputs are forced to 0 and the timer and state are frozen. busy stays 1.
  - When pressure_ok returns to 1, the run resumes with the remaining count; the hold cycles are not charged to the phase.
- Abort:
  - abort=1 in any active state (including during hold): next cycle all valves 0, state IDLE, busy 0, aborted=1 for one cycle, done not asserted.
  - abort in IDLE or DONE has no effect.
  - If start and abort are both high in IDLE, start wins.
- Reset mid-run: all outputs return to reset values immediately (asynchronous); no completion pulse is generated.

Optional Feature:
- Macro: MIXTREE_CYCLE_COUNT_EN.
- When defined:
  - run_cycles clears on an accepted start and increments every busy cycle, including hold.
  - It saturates at 0xFFFF and holds its value in IDLE.
- When undefined: the port and counter are absent.

Decomposition:
- Package mixtree_pkg holds:
  - phase_t enum: IDLE, FILL_A, FILL_B, MIX, DRAIN, DONE.
  - N_MIXERS=7.
  - Per-level mixer masks: 7'h0F, 7'h30, 7'h40.
  - child_a and child_b drain-mask constants per level.
- One sub-module, mixtree_phase_timer: load, enable, and zero flag.

Test Plan:
- Defaults, start pulse → busy for 52 cycles. fill_a=0x0F for cycles 1–4, fill_b=0x0F for 5–8, mix_en=0x0F for 9–16. Level-1 FILL_A has fill_a=0x30 with drain=0x05. DRAIN has drain=0x40. done at cycle 53.
- pressure_ok low for 10 cycles during the level-0 MIX phase → valves 0 and phase frozen. done is delayed to cycle 63; mix_en totals 8 active cycles.
- abort at cycle 20 → cycle 21: valves 0, busy 0, aborted=1. No done. A fresh start then completes normally.
- start re-pulsed at cycle 10 and simultaneously with abort in IDLE → ignored in-run; start accepted in IDLE.
- rst_n low at cycle 30 → all outputs 0 asynchronously. After release, IDLE; the next start gives the full 52-cycle run.
- With MIXTREE_CYCLE_COUNT_EN, a run including a 10-cycle hold → run_cycles=62, held in IDLE.
